// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : PC owner and instruction fetch stage feeding the sisc IR; fetch
//            timeout/HALT logic enabled by macro IFETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [PC_W-1:0] IM_ADDR,
    output logic            IM_REQ,
    input  logic            IM_ACK,
    input  logic [31:0]     IM_DATA,
    input  logic            PC_WRITE,
    input  logic            BR_TAKEN,
    input  logic            BR_ABS,
    input  logic [PC_W-1:0] BR_TARGET,
    output logic [31:0]     IR,
    output logic            IR_VALID,
    output logic [PC_W-1:0] PC,
    output logic            FAULT
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
`ifdef IFETCH_TIMEOUT_EN
        , ST_HALT = 2'd3
`endif
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("instr_fetch: TIMEOUT must be >= 1");
    end

    state_t            r_state, w_state_n;
    logic [PC_W-1:0]   r_pc, w_pc_n;
    logic [31:0]       r_ir, w_ir_n;
    logic              r_valid, w_valid_n;
    logic              r_req, w_req_n;
    logic [PC_W-1:0]   w_pc_seq, w_pc_br;

`ifdef IFETCH_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_cnt, w_cnt_n;
    logic               r_fault, w_fault_n;
`endif

    // Relative targets are offsets from the sequential successor.
    assign w_pc_seq = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_pc_br  = BR_ABS ? BR_TARGET : (w_pc_seq + BR_TARGET);

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_ir_n    = r_ir;
        w_valid_n = r_valid;
        w_req_n   = r_req;
`ifdef IFETCH_TIMEOUT_EN
        w_cnt_n   = r_cnt;
        w_fault_n = r_fault;
`endif
        case (r_state)
            ST_START: begin
                w_state_n = ST_WAIT;
                w_req_n   = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                w_cnt_n   = '0;
`endif
            end
            ST_WAIT: begin
                if (IM_ACK) begin
                    w_ir_n    = IM_DATA;
                    w_valid_n = 1'b1;
                    w_req_n   = 1'b0;
                    w_state_n = ST_READY;
                end
`ifdef IFETCH_TIMEOUT_EN
                // This cycle is the TIMEOUT-th without ack; a same-cycle ack wins above.
                else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                    w_fault_n = 1'b1;
                    w_req_n   = 1'b0;
                    w_valid_n = 1'b0;
                    w_state_n = ST_HALT;
                end else begin
                    w_cnt_n = r_cnt + c_CNT_W'(1);
                end
`endif
            end
            ST_READY: begin
                if (PC_WRITE) begin
                    w_pc_n    = BR_TAKEN ? w_pc_br : w_pc_seq;
                    w_valid_n = 1'b0;
                    w_req_n   = 1'b1;
                    w_state_n = ST_WAIT;
`ifdef IFETCH_TIMEOUT_EN
                    w_cnt_n   = '0;
`endif
                end
            end
`ifdef IFETCH_TIMEOUT_EN
            ST_HALT: begin
            end
`endif
            default: begin
                w_state_n = ST_START;
                w_req_n   = 1'b0;
                w_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_START;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            r_cnt   <= '0;
            r_fault <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_ir    <= w_ir_n;
            r_valid <= w_valid_n;
            r_req   <= w_req_n;
`ifdef IFETCH_TIMEOUT_EN
            r_cnt   <= w_cnt_n;
            r_fault <= w_fault_n;
`endif
        end
    end

    assign IM_ADDR  = r_pc;
    assign PC       = r_pc;
    assign IM_REQ   = r_req;
    assign IR       = r_ir;
    assign IR_VALID = r_valid;
`ifdef IFETCH_TIMEOUT_EN
    assign FAULT    = r_fault;
`else
    assign FAULT    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the sisc datapath/control top.
- Owns the program counter and issues read requests to an instruction memory with a req/ack handshake.
- Captures the returned word into the IR register that drives the datapath's IR input, and holds it until control consumes it.
- Computes the next PC as sequential, relative branch, or absolute branch.

Parameters:
- PC_W, 16, program counter / instruction address width in words.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, max WAIT cycles without IM_ACK before fault. Used only with IFETCH_TIMEOUT_EN; must be >= 1.

Ports:
- CLK  in  1  clock; all state on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IM_ADDR  out  PC_W  instruction memory word address. Always equals PC.
- IM_REQ  out  1  registered read request.
- IM_ACK  in  1  memory ack; IM_DATA is valid in the same cycle.
- IM_DATA  in  32  instruction word from memory.
- PC_WRITE  in  1  from ctrl: current IR consumed, advance PC.
- BR_TAKEN  in  1  from ctrl: branch taken. Sampled only with PC_WRITE.
- BR_ABS  in  1  1 = absolute target, 0 = PC-relative. Sampled only with PC_WRITE.
- BR_TARGET  in  PC_W  branch target or two's-complement offset (imm field).
- IR  out  32  instruction register to the datapath.
- IR_VALID  out  1  IR holds a fetched, unconsumed instruction.
- PC  out  PC_W  current program counter.
- FAULT  out  1  sticky fetch timeout flag. Always present; tied 0 when the feature is off.

Behaviour:
- Reset (RST high, asynchronous):
  - PC = RESET_PC, IR = 0, IR_VALID = 0, IM_REQ = 0, FAULT = 0, state START, timeout counter = 0.
  - Reset asserted mid-transaction abandons the request. A late IM_ACK after reset is ignored, since the FSM is in START.
- States START, WAIT, READY, and HALT (HALT exists only with IFETCH_TIMEOUT_EN). All outputs are registered.
- START: next edge go to WAIT with IM_REQ = 1.
- WAIT:
  - IM_REQ held at 1 until IM_ACK.
  - On the edge where IM_ACK = 1: IR <= IM_DATA, IR_VALID <= 1, IM_REQ <= 0, go to READY.
  - PC_WRITE is ignored in WAIT.
- READY:
  - IR and PC are held stable while PC_WRITE = 0.
  - When PC_WRITE = 1, on the next edge:
    - If BR_TAKEN = 0: PC <= PC + 1.
    - If BR_TAKEN = 1 and BR_ABS = 1: PC <= BR_TARGET.
    - If BR_TAKEN = 1 and BR_ABS = 0: PC <= PC + 1 + BR_TARGET.
    - In the same edge: IR_VALID <= 0, IM_REQ <= 1, go to WAIT.
    - IR keeps its old value until the new word arrives.
- Arithmetic is modulo 2^PC_W, with silent wrap; e.g. PC = all-ones + 1 gives 0.
- IM_ACK outside WAIT is ignored.
- IM_DATA is sampled only on the ack edge.
- Throughput with a zero-wait memory (IM_ACK high in the first WAIT cycle): one instruction per 2 cycles.
- First IR_VALID after reset release is at cycle 3 at the earliest: START, then WAIT, then READY.
- PC_WRITE and IM_ACK in the same cycle cannot both act, since they are legal only in different states. Whichever matches the current state wins.

Optional Feature:
- Macro IFETCH_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments on each WAIT cycle without IM_ACK.
  - When it reaches TIMEOUT: FAULT <= 1, IM_REQ <= 0, IR_VALID <= 0, go to HALT.
  - HALT is left only by RST. IM_ACK and PC_WRITE are ignored in HALT.
  - An IM_ACK arriving in the cycle the count reaches TIMEOUT wins: normal capture, no fault.
- Undefined: no counter and no HALT state. WAIT waits indefinitely; FAULT is constant 0.

Test Plan:
1. Reset and first fetch, zero-wait memory returning 0x1F00_0000 at address 0:
   - Release RST.
   - Expect IM_REQ = 1 and IM_ADDR = 0 in cycle 2, then IR = 0x1F00_0000 and IR_VALID = 1 in cycle 3. PC = 0 throughout.
2. Sequential run:
   - Pulse PC_WRITE with BR_TAKEN = 0, three times.
   - Expect PC sequence 1, 2, 3, with IM_ADDR matching, and IR_VALID low for exactly 1 cycle each step.
3. Branches:
   - PC = 5, relative, BR_TARGET = 0xFFFE (-2): expect next PC 4.
   - PC = 5, absolute, BR_TARGET = 0x0040: expect next PC 0x0040.
   - PC = 0xFFFF, sequential: expect PC 0x0000 (wrap).
4. Stalled memory:
   - Hold IM_ACK = 0 for 6 cycles.
   - Expect IM_REQ held at 1, IR unchanged, PC_WRITE pulses ignored, PC unchanged. Ack with 0xABCD_1234: expect IR updated the next cycle.
5. Async reset mid-WAIT:
   - Assert RST between edges.
   - Expect IM_REQ = 0, IR = 0, PC = RESET_PC immediately, without waiting for a clock edge. An IM_ACK in the following START cycle is ignored.
6. With IFETCH_TIMEOUT_EN and TIMEOUT = 15, never ack:
   - Expect FAULT = 1 and IM_REQ = 0 after 15 WAIT cycles, remaining in HALT until RST.
   - Repeat with the ack on the 15th cycle: expect normal capture and FAULT = 0.
